// File: rtl/song_pkg.sv
// Shared definitions for the song sequencer: note codes, FSM states and the
// constant song table read by song_rom.
package song_pkg;

  // Native field widths of the stored table entries.
  localparam int TBL_NOTE_W = 4;
  localparam int TBL_DUR_W  = 2;
  localparam int TBL_LEN    = 16;

  localparam logic [3:0] NOTE_A    = 4'd0;
  localparam logic [3:0] NOTE_B    = 4'd1;
  localparam logic [3:0] NOTE_C    = 4'd2;
  localparam logic [3:0] NOTE_D    = 4'd3;
  localparam logic [3:0] NOTE_E    = 4'd4;
  localparam logic [3:0] NOTE_F    = 4'd5;
  localparam logic [3:0] NOTE_G    = 4'd6;
  localparam logic [3:0] NOTE_REST = 4'd7;
  localparam logic [3:0] NOTE_END  = 4'd8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_PLAY = 2'd2,
    ST_GAP  = 2'd3
  } state_t;

  typedef struct packed {
    logic [TBL_DUR_W-1:0]  dur;
    logic [TBL_NOTE_W-1:0] note;
  } entry_t;

  function automatic entry_t mk(input int dur, input int note);
    return '{dur: TBL_DUR_W'(dur), note: TBL_NOTE_W'(note)};
  endfunction

  // Song table. Anything past the last listed entry, or past TBL_LEN, reads
  // as the end code, so unused songs are empty.
  function automatic entry_t song_entry(input int song, input int idx);
    entry_t e;
    e = '{dur: '0, note: NOTE_END};
    if (idx >= 0 && idx < TBL_LEN) begin
      case (song)
        0: case (idx)
             0: e = mk(0, NOTE_A);
             1: e = mk(1, NOTE_G);
             2: e = mk(0, NOTE_D);
             default: ;
           endcase
        1: case (idx)
             0: e = mk(1, NOTE_F);
             1: e = mk(0, NOTE_REST);
             2: e = mk(0, NOTE_B);
             default: ;
           endcase
        2: case (idx)
             0: e = mk(0, NOTE_C);
             1: e = mk(1, NOTE_E);
             default: ;
           endcase
        // Fills every slot with no end code; slot 8 holds code 9 (a rest).
        3: e = mk(idx % 2, (idx == 8) ? 9 : idx);
        4: case (idx)
             0: e = mk(3, NOTE_B);
             1: e = mk(0, 12);
             2: e = mk(2, NOTE_A);
             default: ;
           endcase
        5: case (idx)
             0: e = mk(0, NOTE_G);
             default: ;
           endcase
        6: case (idx)
             0: e = mk(2, NOTE_D);
             1: e = mk(1, NOTE_C);
             2: e = mk(0, NOTE_E);
             3: e = mk(0, NOTE_F);
             default: ;
           endcase
        default: ;
      endcase
    end
    return e;
  endfunction

endpackage

// File: rtl/song_sequencer_rom.sv
// Registered synchronous read of the song table: address in, {dur, note}
// out one clock later.
module song_rom
  import song_pkg::*;
#(
  parameter int NOTE_W = 4,
  parameter int DUR_W  = 2,
  parameter int SONG_W = 3,
  parameter int IDX_W  = 5
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [SONG_W-1:0] song,
  input  logic [IDX_W-1:0]  idx,
  output logic [NOTE_W-1:0] note,
  output logic [DUR_W-1:0]  dur
);

  entry_t rd;

  // Table lookup for the presented address.
  always_comb rd = song_entry(int'(song), int'(idx));

  // Output register; one cycle of read latency.
  // NOTE: the table is constant logic, so only this output register needs a
  // reset; it comes up holding the end code rather than X.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      note <= NOTE_W'(NOTE_END);
      dur  <= '0;
    end else begin
      note <= NOTE_W'(rd.note);
      dur  <= DUR_W'(rd.dur);
    end
  end

endmodule

// File: rtl/song_sequencer.sv
// Song sequencer: plays one stored note sequence to the tone generator with
// per-note duration, a muted gap after each note, loop mode and abort.
module song_sequencer
  import song_pkg::*;
#(
  parameter int NOTE_W     = 4,
  parameter int DUR_W      = 2,
  parameter int NUM_SONGS  = 8,
  parameter int SONG_LEN   = 16,
  parameter int BEAT_TICKS = 12_500_000,
  parameter int GAP_TICKS  = 1_250_000
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         start,
  input  logic [$clog2(NUM_SONGS)-1:0] song_sel,
  input  logic                         loop,
  input  logic                         abort,
  output logic [NOTE_W-1:0]            note_select,
  output logic                         busy,
  output logic                         seq_end
);

  localparam int SONG_W   = $clog2(NUM_SONGS);
  localparam int IDX_W    = $clog2(SONG_LEN + 1);
  localparam int PLAY_MAX = (2 ** DUR_W) * BEAT_TICKS;
  // Shared down-counter for note and gap, sized for the longer of the two.
  localparam int CNT_W    = $clog2((PLAY_MAX > GAP_TICKS) ? PLAY_MAX : GAP_TICKS);
  localparam logic [NOTE_W-1:0] REST = NOTE_W'(NOTE_REST);

  state_t              state_q, state_d;
  logic [SONG_W-1:0]   song_q, song_d;
  logic                loop_q, loop_d;
  logic [IDX_W-1:0]    idx_q, idx_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [NOTE_W-1:0]   note_d;
  logic                busy_d, end_d;
  logic [NOTE_W-1:0]   rom_note;
  logic [DUR_W-1:0]    rom_dur;

  // Codes A..G pass through; 7 and anything above the end code sound as rest.
  function automatic logic [NOTE_W-1:0] tone_code(input logic [NOTE_W-1:0] code);
    return (code <= NOTE_W'(NOTE_G)) ? code : REST;
  endfunction

  // The ROM is addressed with next-state song/index, so the entry is ready
  // on the cycle the FSM sits in LOAD.
  song_rom #(
    .NOTE_W(NOTE_W),
    .DUR_W (DUR_W),
    .SONG_W(SONG_W),
    .IDX_W (IDX_W)
  ) u_rom (
    .clk  (clk),
    .reset(reset),
    .song (song_d),
    .idx  (idx_d),
    .note (rom_note),
    .dur  (rom_dur)
  );

  // Next-state and next-output logic; abort overrides everything.
  // NOTE: every variable gets a default before the case, so no path can
  // leave one unassigned and infer a latch.
  always_comb begin
    state_d = state_q;
    song_d  = song_q;
    loop_d  = loop_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    note_d  = REST;
    busy_d  = busy;
    end_d   = 1'b0;
    if (abort) begin
      state_d = ST_IDLE;
      idx_d   = '0;
      cnt_d   = '0;
      busy_d  = 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            state_d = ST_LOAD;
            song_d  = (int'(song_sel) < NUM_SONGS) ? song_sel : '0;
            loop_d  = loop;
            idx_d   = '0;
            busy_d  = 1'b1;
          end
        end
        ST_LOAD: begin
          if (rom_note == NOTE_W'(NOTE_END) || idx_q == IDX_W'(SONG_LEN)) begin
            idx_d = '0;
            if (loop_q) begin
              state_d = ST_LOAD;
            end else begin
              state_d = ST_IDLE;
              busy_d  = 1'b0;
              end_d   = 1'b1;
            end
          end else begin
            state_d = ST_PLAY;
            cnt_d   = CNT_W'((int'(rom_dur) + 1) * BEAT_TICKS - 1);
            note_d  = tone_code(rom_note);
          end
        end
        ST_PLAY: begin
          if (cnt_q == '0) begin
            if (GAP_TICKS == 0) begin
              state_d = ST_LOAD;
              idx_d   = idx_q + IDX_W'(1);
            end else begin
              state_d = ST_GAP;
              cnt_d   = CNT_W'(GAP_TICKS - 1);
            end
          end else begin
            cnt_d  = cnt_q - CNT_W'(1);
            note_d = note_select;
          end
        end
        ST_GAP: begin
          if (cnt_q == '0) begin
            state_d = ST_LOAD;
            idx_d   = idx_q + IDX_W'(1);
          end else begin
            cnt_d = cnt_q - CNT_W'(1);
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // State and registered outputs.
  // NOTE: non-blocking assignments here so every register samples the
  // pre-edge values computed above, independent of statement order.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= ST_IDLE;
      song_q      <= '0;
      loop_q      <= 1'b0;
      idx_q       <= '0;
      cnt_q       <= '0;
      note_select <= REST;
      busy        <= 1'b0;
      seq_end     <= 1'b0;
    end else begin
      state_q     <= state_d;
      song_q      <= song_d;
      loop_q      <= loop_d;
      idx_q       <= idx_d;
      cnt_q       <= cnt_d;
      note_select <= note_d;
      busy        <= busy_d;
      seq_end     <= end_d;
    end
  end

endmodule

// File: tb/tb_song_sequencer.sv
// Self-checking bench for song_sequencer: a run-length vector table, a few
// hand-written corner sequences and a randomized run against a trace model.
module tb_song_sequencer;
  import song_pkg::*;

  localparam int BT   = 4;
  localparam int GT   = 2;
  localparam int SLEN = 16;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       start = 1'b0;
  logic       loop = 1'b0;
  logic       abort = 1'b0;
  logic [2:0] song_sel = 3'd0;
  logic [3:0] note8, note5;
  logic       busy8, busy5, end8, end5;

  // Full eight-song instance and a five-song instance for out-of-range selects.
  song_sequencer #(.NOTE_W(4), .DUR_W(2), .NUM_SONGS(8), .SONG_LEN(SLEN),
                   .BEAT_TICKS(BT), .GAP_TICKS(GT)) dut8 (
    .clk(clk), .reset(reset), .start(start), .song_sel(song_sel), .loop(loop),
    .abort(abort), .note_select(note8), .busy(busy8), .seq_end(end8));

  song_sequencer #(.NOTE_W(4), .DUR_W(2), .NUM_SONGS(5), .SONG_LEN(SLEN),
                   .BEAT_TICKS(BT), .GAP_TICKS(GT)) dut5 (
    .clk(clk), .reset(reset), .start(start), .song_sel(song_sel), .loop(loop),
    .abort(abort), .note_select(note5), .busy(busy5), .seq_end(end5));

  always #5 clk = ~clk;

  int n_pass = 0;
  int n_total = 0;

  task automatic check(input string name, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got 'h%0h expected 'h%0h at %0t", name, act, exp, $time);
  endtask

  // Expected observation after a clock edge: {note_select, busy, seq_end}.
  typedef struct packed {
    logic [3:0] note;
    logic       busy;
    logic       sq;
  } obs_t;

  localparam obs_t IDLE_OBS = '{note: 4'd7, busy: 1'b0, sq: 1'b0};
  localparam obs_t SIL_OBS  = '{note: 4'd7, busy: 1'b1, sq: 1'b0};

  // Trace model: on an accepted start the whole pass of the song is expanded
  // into a list of per-cycle observations, which are then consumed one per edge.
  obs_t mbuf [2][512];
  int   mlen [2];
  int   mrd  [2];
  bit   mloop[2];
  bit   mbusy[2];
  int   msong[2];
  obs_t mexp [2];

  task automatic push(input int k, input obs_t o);
    mbuf[k][mlen[k]] = o;
    mlen[k]++;
  endtask

  task automatic build_pass(input int k);
    entry_t e;
    logic [3:0] tone;
    mlen[k] = 0;
    mrd[k]  = 0;
    for (int i = 0; i <= SLEN; i++) begin
      push(k, SIL_OBS);                       // the LOAD cycle
      if (i == SLEN) break;
      e = song_entry(msong[k], i);
      if (e.note == NOTE_END) break;
      tone = (e.note <= 4'd6) ? e.note : 4'd7;
      repeat ((int'(e.dur) + 1) * BT) push(k, '{note: tone, busy: 1'b1, sq: 1'b0});
      repeat (GT) push(k, SIL_OBS);
    end
    if (!mloop[k]) push(k, '{note: 4'd7, busy: 1'b0, sq: 1'b1});
  endtask

  function automatic int map_song(input int k);
    if (k == 0) return int'(song_sel);
    return (song_sel < 3'd5) ? int'(song_sel) : 0;
  endfunction

  task automatic model_edge(input int k);
    if (!reset || abort) begin
      mlen[k]  = 0;
      mrd[k]   = 0;
      mloop[k] = 1'b0;
      mexp[k]  = IDLE_OBS;
    end else begin
      if (!mbusy[k] && start) begin
        msong[k] = map_song(k);
        mloop[k] = loop;
        build_pass(k);
      end else if (mrd[k] >= mlen[k] && mloop[k]) begin
        build_pass(k);
      end
      if (mrd[k] < mlen[k]) begin
        mexp[k] = mbuf[k][mrd[k]];
        mrd[k]++;
      end else begin
        mexp[k] = IDLE_OBS;
      end
    end
    mbusy[k] = mexp[k].busy;
  endtask

  // One clock: model advances with the edge, outputs are sampled 1 ns later.
  task automatic tick();
    @(posedge clk);
    model_edge(0);
    model_edge(1);
    #1;
  endtask

  task automatic tick_chk(input string name);
    tick();
    check({name, "_8"}, int'({note8, busy8, end8}), int'(mexp[0]));
    check({name, "_5"}, int'({note5, busy5, end5}), int'(mexp[1]));
  endtask

  typedef struct {
    logic       start;
    logic [2:0] sel;
    logic       lp;
    logic       ab;
    logic [3:0] note;
    logic       busy;
    logic       sq;
    int         rep;
  } vec_t;

  vec_t vt[$];

  task automatic add(input logic s, input int sel, input logic lp, input logic ab,
                     input int note, input logic b, input logic sq, input int rep);
    vec_t v;
    v = '{start: s, sel: 3'(sel), lp: lp, ab: ab, note: 4'(note), busy: b, sq: sq, rep: rep};
    vt.push_back(v);
  endtask

  initial begin
    #200_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int onsets, ends, n;
    logic [3:0] prev;

    // Song 2 {C d0, E d1, END}: LOAD, 4 of C, gap+LOAD, 8 of E, gap+LOAD, end pulse.
    add(1, 2, 0, 0, 7, 1, 0, 1);
    add(0, 0, 0, 0, 2, 1, 0, 4);
    add(0, 0, 0, 0, 7, 1, 0, 3);
    add(0, 0, 0, 0, 4, 1, 0, 8);
    add(0, 0, 0, 0, 7, 1, 0, 3);
    add(0, 0, 0, 0, 7, 0, 1, 1);
    add(0, 0, 0, 0, 7, 0, 0, 2);
    // Empty song 7: end pulse two cycles after start, never a note.
    add(1, 7, 0, 0, 7, 1, 0, 1);
    add(0, 0, 0, 0, 7, 0, 1, 1);
    add(0, 0, 0, 0, 7, 0, 0, 2);
    // abort together with start: stays idle.
    add(1, 2, 0, 1, 7, 0, 0, 3);
    // Song 5 {G d0, END} with start re-pulsed while busy on other songs.
    add(1, 5, 0, 0, 7, 1, 0, 1);
    add(1, 2, 1, 0, 6, 1, 0, 1);
    add(0, 0, 0, 0, 6, 1, 0, 3);
    add(1, 3, 0, 0, 7, 1, 0, 3);
    add(0, 0, 0, 0, 7, 0, 1, 1);
    add(0, 0, 0, 0, 7, 0, 0, 1);
    // abort mid-note: idle next cycle, no end pulse afterwards.
    add(1, 2, 0, 0, 7, 1, 0, 1);
    add(0, 0, 0, 0, 2, 1, 0, 2);
    add(0, 0, 0, 1, 7, 0, 0, 1);
    add(0, 0, 0, 0, 7, 0, 0, 3);
    // Empty song in loop mode spins in LOAD until aborted.
    add(1, 7, 1, 0, 7, 1, 0, 1);
    add(0, 0, 0, 0, 7, 1, 0, 4);
    add(0, 0, 0, 1, 7, 0, 0, 1);
    // Song 4 {B d3, code 12 d0, A d2, END}: code 12 sounds as rest.
    add(1, 4, 0, 0, 7, 1, 0, 1);
    add(0, 0, 0, 0, 1, 1, 0, 16);
    add(0, 0, 0, 0, 7, 1, 0, 10);
    add(0, 0, 0, 0, 0, 1, 0, 12);
    add(0, 0, 0, 0, 7, 1, 0, 3);
    add(0, 0, 0, 0, 7, 0, 1, 1);
    add(0, 0, 0, 0, 7, 0, 0, 1);

    // Reset state, asserted before any clock edge.
    #1 reset = 1'b0;
    #1;
    check("reset_async_8", int'({note8, busy8, end8}), int'(IDLE_OBS));
    check("reset_async_5", int'({note5, busy5, end5}), int'(IDLE_OBS));
    tick_chk("reset_hold");
    tick_chk("reset_hold");
    reset = 1'b1;
    tick_chk("idle");

    foreach (vt[v]) begin
      for (int r = 0; r < vt[v].rep; r++) begin
        start    = vt[v].start;
        song_sel = vt[v].sel;
        loop     = vt[v].lp;
        abort    = vt[v].ab;
        tick();
        check($sformatf("vec%0d", v), int'({note8, busy8, end8}),
              int'({vt[v].note, vt[v].busy, vt[v].sq}));
        check($sformatf("vec%0d_model5", v), int'({note5, busy5, end5}), int'(mexp[1]));
      end
    end
    start = 1'b0; abort = 1'b0; loop = 1'b0;

    // Out-of-range select on the five-song instance plays song 0.
    song_sel = 3'd6; start = 1'b1;
    tick_chk("oor_load");
    start = 1'b0;
    tick_chk("oor_play");
    check("oor_song0_note", note5, 0);
    check("sel6_song6_note", note8, 3);
    abort = 1'b1;
    tick_chk("oor_abort");
    abort = 1'b0;

    // Loop mode: at least three passes of song 2, no end pulse, then abort.
    song_sel = 3'd2; loop = 1'b1; start = 1'b1;
    tick_chk("loop_start");
    start = 1'b0; loop = 1'b0;
    onsets = 0; ends = 0; prev = 4'd7;
    for (int i = 0; i < 60; i++) begin
      tick_chk("loop_run");
      if (note8 == 4'd2 && prev != 4'd2) onsets++;
      if (end8) ends++;
      prev = note8;
    end
    check("loop_passes_ge3", int'(onsets >= 3), 1);
    abort = 1'b1;
    tick();
    check("loop_abort_idle", int'({note8, busy8, end8}), int'(IDLE_OBS));
    abort = 1'b0;
    for (int i = 0; i < 6; i++) begin
      tick_chk("post_abort");
      if (end8) ends++;
    end
    check("loop_no_seq_end", ends, 0);

    // Asynchronous reset between clock edges in the middle of a note.
    song_sel = 3'd2; start = 1'b1;
    tick_chk("rst_mid_load");
    start = 1'b0;
    tick_chk("rst_mid_play");
    tick_chk("rst_mid_play");
    #3 reset = 1'b0;
    #1;
    check("reset_mid_play_8", int'({note8, busy8, end8}), int'(IDLE_OBS));
    check("reset_mid_play_5", int'({note5, busy5, end5}), int'(IDLE_OBS));
    tick_chk("rst_hold");
    reset = 1'b1;
    start = 1'b1;
    tick_chk("restart_load");
    start = 1'b0;
    tick_chk("restart_play");
    check("restart_first_note", note8, 2);

    // Run the restarted song out, then song 3 which fills every slot.
    n = 0;
    while (busy8 && n < 100) begin
      tick_chk("restart_drain");
      n++;
    end
    check("restart_drained", int'(busy8), 0);
    song_sel = 3'd3; start = 1'b1;
    tick_chk("full_start");
    start = 1'b0;
    n = 1;
    while (!end8 && n < 400) begin
      tick_chk("full_run");
      n++;
    end
    // 16 entries of LOAD + gap, beats alternate 1 and 2, then the final LOAD.
    check("full_song_end_cycle", n, SLEN * (1 + GT) + BT * (8 * 1 + 8 * 2) + 2);
    tick_chk("full_after");

    // Randomized traffic against the trace model.
    for (int i = 0; i < 3000; i++) begin
      start    = ($urandom_range(0, 7) == 0);
      song_sel = 3'($urandom_range(0, 7));
      loop     = ($urandom_range(0, 3) == 0);
      abort    = ($urandom_range(0, 63) == 0);
      tick_chk("rand");
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
